// File: rtl/dw_bsr_bidir_if.sv
// dw_bsr_bidir_if -- bus bundle for one bidirectional boundary scan segment.
//
// Groups the TAP strobes, the scan path and the core/pad data signals.
//   master : TAP controller / core / pad side (drives strobes and sources)
//   slave  : the boundary scan segment itself
//
// Signals:
//   capture_dr, shift_dr, update_dr  TAP decoded DR strobes
//   mode[1:0]                        00 NORMAL, 01 EXTEST, 10 INTEST, 11 SAFE
//   si / so                          serial scan in / out
//   pin_input[N-1:0]                 pad receive data
//   output_data[N-1:0]               core transmit data
//   core_oe[N-1:0]                   core output enable
//   ic_input[N-1:0]                  data to core input logic
//   data_out[N-1:0]                  data to pad
//   pad_oe[N-1:0]                    pad output enable
//   shift_err                        shift-length error flag
interface dw_bsr_bidir_if #(
    parameter int N = 8
);
    logic         capture_dr;
    logic         shift_dr;
    logic         update_dr;
    logic [1:0]   mode;
    logic         si;
    logic [N-1:0] pin_input;
    logic [N-1:0] output_data;
    logic [N-1:0] core_oe;
    logic [N-1:0] ic_input;
    logic [N-1:0] data_out;
    logic [N-1:0] pad_oe;
    logic         so;
    logic         shift_err;

    modport master (
        output capture_dr, shift_dr, update_dr, mode, si,
               pin_input, output_data, core_oe,
        input  ic_input, data_out, pad_oe, so, shift_err
    );

    modport slave (
        input  capture_dr, shift_dr, update_dr, mode, si,
               pin_input, output_data, core_oe,
        output ic_input, data_out, pad_oe, so, shift_err
    );
endinterface

// File: rtl/dw_bsr_bidir.sv
// dw_bsr_bidir -- N-channel bidirectional boundary scan register segment.
//
// Each channel owns a control cell (drives pad output enable) and a data
// cell (observes the pin, drives pad data). Chain order from si:
//   ctrl[0], data[0], ctrl[1], data[1], ..., ctrl[N-1], data[N-1] -> so
// Chain bit 2*i is ctrl[i], bit 2*i+1 is data[i]; so is the registered
// capture cell of data[N-1].
//
// Ports:
//   clk   single scan/system clock, rising edge
//   rst   synchronous active-high reset
//   bus   dw_bsr_bidir_if.slave (strobes, mode, scan path, core/pad data)
//
// Parameters:
//   N          number of bidirectional channels (chain length 2*N)
//   SAFE_OE    pad_oe forced in SAFE mode
//   SAFE_DATA  data_out forced in SAFE mode
//
// Build option:
//   BSR_SHIFT_CHK_EN  when defined, counts shift_dr edges since the last
//                     capture_dr and blocks any update_dr whose shift count
//                     is not exactly 2*N, raising sticky shift_err. When
//                     undefined, every update_dr updates and shift_err is 0.
module dw_bsr_bidir #(
    parameter int           N         = 8,
    parameter logic [N-1:0] SAFE_OE   = '0,
    parameter logic [N-1:0] SAFE_DATA = '0
) (
    input  logic           clk,
    input  logic           rst,
    dw_bsr_bidir_if.slave  bus
);
    localparam int L = 2 * N;

    typedef enum logic [1:0] {
        M_NORMAL = 2'b00,
        M_EXTEST = 2'b01,
        M_INTEST = 2'b10,
        M_SAFE   = 2'b11
    } mode_e;

    mode_e        mode;
    logic [L-1:0] cap_src;
    logic [L-1:0] cap;
    logic [L-1:0] upd;
    logic         upd_ok;

    assign mode = mode_e'(bus.mode);

    // Parallel capture sources: ctrl cells always see core_oe; data cells
    // see the core's transmit data in INTEST, the pin otherwise.
    for (genvar i = 0; i < N; i++) begin : g_src
        assign cap_src[2*i]   = bus.core_oe[i];
        assign cap_src[2*i+1] = (mode == M_INTEST) ? bus.output_data[i]
                                                   : bus.pin_input[i];
    end

    // Capture stage: rst > capture_dr > shift_dr > hold.
    always_ff @(posedge clk) begin
        if (rst)
            cap <= '0;
        else if (bus.capture_dr)
            cap <= cap_src;
        else if (bus.shift_dr)
            cap <= {cap[L-2:0], bus.si};
    end

    // Update stage samples the pre-edge capture value, so a simultaneous
    // capture or shift does not leak into the update.
    always_ff @(posedge clk) begin
        if (rst)
            upd <= '0;
        else if (bus.update_dr && upd_ok)
            upd <= cap;
    end

    assign bus.so = cap[L-1];

`ifdef BSR_SHIFT_CHK_EN
    localparam int             CW       = $clog2(L + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(L);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(L + 1);

    logic [CW-1:0] shift_cnt;
    logic          err_q;

    // Saturating at L+1 keeps an over-shift distinguishable from an exact one.
    always_ff @(posedge clk) begin
        if (rst || bus.capture_dr)
            shift_cnt <= '0;
        else if (bus.shift_dr && shift_cnt != CNT_SAT)
            shift_cnt <= shift_cnt + CW'(1);
    end

    assign upd_ok = (shift_cnt == CNT_FULL);

    // A rejected update on the same edge as capture_dr still reports: the
    // failure belongs to the scan that just ended.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (bus.update_dr && !upd_ok)
            err_q <= 1'b1;
        else if (bus.capture_dr)
            err_q <= 1'b0;
    end

    assign bus.shift_err = err_q;
`else
    assign upd_ok        = 1'b1;
    assign bus.shift_err = 1'b0;
`endif

    // Output steering; purely combinational so mode changes act at once.
    logic [N-1:0] pad_oe_w;
    logic [N-1:0] data_out_w;
    logic [N-1:0] ic_input_w;

    always_comb begin
        pad_oe_w   = bus.core_oe;
        data_out_w = bus.output_data;
        ic_input_w = bus.pin_input;
        for (int i = 0; i < N; i++) begin
            unique case (mode)
                M_NORMAL: ;
                M_EXTEST: begin
                    pad_oe_w[i]   = upd[2*i];
                    data_out_w[i] = upd[2*i+1];
                end
                M_INTEST: begin
                    pad_oe_w[i]   = 1'b0;
                    ic_input_w[i] = upd[2*i+1];
                end
                M_SAFE: begin
                    pad_oe_w[i]   = SAFE_OE[i];
                    data_out_w[i] = SAFE_DATA[i];
                end
                default: ;
            endcase
        end
    end

    assign bus.pad_oe   = pad_oe_w;
    assign bus.data_out = data_out_w;
    assign bus.ic_input = ic_input_w;

endmodule

// File: tb/tb_dw_bsr_bidir.sv
// tb_dw_bsr_bidir -- directed, table-driven bench for dw_bsr_bidir (N=4).
// Each vector drives one clock of strobes/inputs and checks the outputs
// 1 time unit after the rising edge.
module tb_dw_bsr_bidir;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dw_bsr_bidir_if #(.N(N)) bus ();

    dw_bsr_bidir #(
        .N        (N),
        .SAFE_OE  (4'h3),
        .SAFE_DATA(4'h1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] ctl;   // {rst, capture_dr, shift_dr, update_dr}
        logic [1:0] mode;
        logic       si;
        logic [3:0] pin, od, oe;
        logic [3:0] e_oe, e_do, e_ic;
        logic       e_so, e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [3:0] ctl, input logic [1:0] mode,
                                input logic si, input logic [3:0] pin,
                                input logic [3:0] od, input logic [3:0] oe,
                                input logic [3:0] e_oe, input logic [3:0] e_do,
                                input logic [3:0] e_ic, input logic e_so,
                                input logic e_err);
        vec_t v;
        v.ctl = ctl; v.mode = mode; v.si = si; v.pin = pin; v.od = od; v.oe = oe;
        v.e_oe = e_oe; v.e_do = e_do; v.e_ic = e_ic; v.e_so = e_so; v.e_err = e_err;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        rst             = v.ctl[3];
        bus.capture_dr  = v.ctl[2];
        bus.shift_dr    = v.ctl[1];
        bus.update_dr   = v.ctl[0];
        bus.mode        = v.mode;
        bus.si          = v.si;
        bus.pin_input   = v.pin;
        bus.output_data = v.od;
        bus.core_oe     = v.oe;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.pad_oe !== v.e_oe || bus.data_out !== v.e_do ||
            bus.ic_input !== v.e_ic || bus.so !== v.e_so ||
            bus.shift_err !== v.e_err) begin
            n_bad++;
            $display("FAIL %s[%0d]: got pad_oe=%h data_out=%h ic_input=%h so=%b shift_err=%b, want %h %h %h %b %b",
                     tag, idx, bus.pad_oe, bus.data_out, bus.ic_input, bus.so,
                     bus.shift_err, v.e_oe, v.e_do, v.e_ic, v.e_so, v.e_err);
        end
    endtask

    // Shift 8 bits (si_bits[7] first) with expected so after each edge.
    task automatic shift8(input logic [1:0] mode, input logic [7:0] si_bits,
                          input logic [7:0] so_bits, input logic [3:0] pin,
                          input logic [3:0] od, input logic [3:0] oe,
                          input logic [3:0] e_oe, input logic [3:0] e_do,
                          input logic [3:0] e_ic, input logic e_err,
                          input int cnt, input string tag);
        for (int k = 0; k < cnt; k++)
            apply(mk(4'b0010, mode, si_bits[7-k], pin, od, oe, e_oe, e_do, e_ic,
                     so_bits[7-k], e_err), tag, k);
    endtask

    logic [7:0] si_ext, so_ext, si_int, so_int;

    initial begin
        bus.capture_dr = 1'b0; bus.shift_dr = 1'b0; bus.update_dr = 1'b0;
        bus.mode = 2'b01; bus.si = 1'b0;
        bus.pin_input = '0; bus.output_data = '0; bus.core_oe = '0;

        // EXTEST stream: first bit lands in data[3]; gives ctrl=data=4'b1101.
        si_ext = 8'b1111_0011;
        so_ext = 8'b1110_1111;   // replays captured 0x77 from bit 6 down, then si
        // INTEST stream: data=4'b1001, ctrl=0; replays captured 0x7D.
        si_int = 8'b1000_0010;
        so_int = 8'b1111_1011;

        // Reset, NORMAL transparency, EXTEST capture.
        tbl.push_back(mk(4'b1000, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 0, 0));
        tbl.push_back(mk(4'b0000, 2'b00, 0, 4'h5, 4'hA, 4'hF, 4'hF, 4'hA, 4'h5, 0, 0));
        tbl.push_back(mk(4'b0100, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(4'b0010, 2'b01, si_ext[7-k], 4'h5, 4'hA, 4'hF,
                             4'h0, 4'h0, 4'h5, so_ext[7-k], 0));
        tbl.push_back(mk(4'b0001, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'hD, 4'hD, 4'h5, 1, 0));
        // INTEST: capture core data 6, shift in 9, update.
        tbl.push_back(mk(4'b0100, 2'b10, 0, 4'h5, 4'h6, 4'hF, 4'h0, 4'h6, 4'hD, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(4'b0010, 2'b10, si_int[7-k], 4'h5, 4'h6, 4'hF,
                             4'h0, 4'h6, 4'hD, so_int[7-k], 0));
        tbl.push_back(mk(4'b0001, 2'b10, 0, 4'h5, 4'h6, 4'hF, 4'h0, 4'h6, 4'h9, 1, 0));
        // SAFE clamp, back to EXTEST (upd kept), NORMAL with new inputs.
        tbl.push_back(mk(4'b0000, 2'b11, 0, 4'h5, 4'h6, 4'hF, 4'h3, 4'h1, 4'h5, 1, 0));
        tbl.push_back(mk(4'b0000, 2'b01, 0, 4'h5, 4'h6, 4'hF, 4'h0, 4'h9, 4'h5, 1, 0));
        tbl.push_back(mk(4'b0000, 2'b00, 0, 4'hA, 4'hC, 4'h3, 4'h3, 4'hC, 4'hA, 1, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], "tbl", i);

`ifndef BSR_SHIFT_CHK_EN
        // Same-edge strobes: capture beats shift; update takes pre-edge cap.
        apply(mk(4'b0110, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h9, 4'h5, 0, 0), "cap_vs_shift", 0);
        apply(mk(4'b0011, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'hF, 4'h5, 4'h5, 1, 0), "upd_w_shift", 0);
        apply(mk(4'b0101, 2'b01, 0, 4'hA, 4'hA, 4'h0, 4'hA, 4'hF, 4'hA, 1, 0), "upd_w_cap", 0);
`endif

        // Reset mid-shift: chain restarts from zero, si->so latency is 8.
        apply(mk(4'b0100, 2'b00, 0, 4'h5, 4'hA, 4'hF, 4'hF, 4'hA, 4'h5, 0, 0), "rst_mid", 0);
        apply(mk(4'b0010, 2'b00, 1, 4'h5, 4'hA, 4'hF, 4'hF, 4'hA, 4'h5, 1, 0), "rst_mid", 1);
        apply(mk(4'b0010, 2'b00, 1, 4'h5, 4'hA, 4'hF, 4'hF, 4'hA, 4'h5, 1, 0), "rst_mid", 2);
        apply(mk(4'b1010, 2'b01, 1, 4'hA, 4'hA, 4'h0, 4'h0, 4'h0, 4'hA, 0, 0), "rst_mid", 3);
        shift8(2'b01, 8'b1000_0000, 8'b0000_0001, 4'hA, 4'hA, 4'h0,
               4'h0, 4'h0, 4'hA, 0, 8, "latency");
        apply(mk(4'b0000, 2'b01, 0, 4'hA, 4'hA, 4'h0, 4'h0, 4'h0, 4'hA, 1, 0), "hold", 0);

`ifdef BSR_SHIFT_CHK_EN
        // Short scan (7 shifts) must not update and must flag.
        apply(mk(4'b0100, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 0, 0), "chk_cap", 0);
        shift8(2'b01, 8'b0000_0000, 8'b1110_1110, 4'h5, 4'hA, 4'hF,
               4'h0, 4'h0, 4'h5, 0, 7, "chk_short");
        apply(mk(4'b0001, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 1, 1), "chk_upd_bad", 0);
        apply(mk(4'b0000, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 1, 1), "chk_sticky", 0);
        apply(mk(4'b0100, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 0, 0), "chk_clear", 0);
        shift8(2'b01, si_ext, so_ext, 4'h5, 4'hA, 4'hF,
               4'h0, 4'h0, 4'h5, 0, 8, "chk_full");
        apply(mk(4'b0001, 2'b01, 0, 4'h5, 4'hA, 4'hF, 4'hD, 4'hD, 4'h5, 1, 0), "chk_upd_ok", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
